// File: rtl/ssy_pkg.sv
// ssy_pkg: shared types and constants for the ssy grant controller.
//   state_t       : FSM state encoding (IDLE, WAIT, GRANT)
//   CNT_W         : width of the shared WAIT/GRANT down-counter
//   DEF_*         : default latency / grant-length values
//   ssy_in_range  : elaboration-time parameter range check
package ssy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2
    } state_t;

    localparam int CNT_W             = 4;
    localparam int DEF_GRANT_LATENCY = 2;
    localparam int DEF_GRANT_LEN     = 1;

    function automatic bit ssy_in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ssy_grant_ctrl_if.sv
// ssy_grant_ctrl_if: request/idle/granted handshake bundle.
//   request : requester -> controller, sampled only while idle=1
//   idle    : controller -> requester, controller can accept a request
//   granted : controller -> requester, grant active
// master = requester side, slave = controller side.
interface ssy_grant_ctrl_if;
    logic request;
    logic idle;
    logic granted;

    modport master (output request, input  idle, input  granted);
    modport slave  (input  request, output idle, output granted);
endinterface

// File: rtl/ssy_down_counter.sv
// ssy_down_counter: loadable down-counter with zero flag.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; saturates at zero
//   zero       : count == 0
//   MAX_VAL    : largest value the owner will ever load (range-checked)
module ssy_down_counter
    import ssy_pkg::*;
#(
    parameter int MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    if (!ssy_in_range(MAX_VAL, 0, (1 << CNT_W) - 1)) begin : g_bad_max
        $fatal(1, "ssy_down_counter: MAX_VAL %0d does not fit in CNT_W", MAX_VAL);
    end

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ssy_grant_ctrl.sv
// ssy_grant_ctrl: single-requester grant sequencer.
//   An accepted request (request=1 while idle=1) produces GRANT_LATENCY cycles
//   later a granted pulse GRANT_LEN cycles long, then returns to idle on the
//   same edge granted falls. Requests while busy are ignored (no queuing).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; aborts any transaction
//   bus   : ssy_grant_ctrl_if.slave (request in, idle/granted out, registered)
// Parameters:
//   GRANT_LATENCY : request cycle -> first granted cycle, 1..15
//   GRANT_LEN     : granted pulse length in cycles, 1..15
// Build option:
//   SSY_ASSERT_EN : compile the embedded SVA (assume/assert/cover).
module ssy_grant_ctrl
    import ssy_pkg::*;
#(
    parameter int GRANT_LATENCY = DEF_GRANT_LATENCY,
    parameter int GRANT_LEN     = DEF_GRANT_LEN
) (
    input  logic              clk,
    input  logic              reset,
    ssy_grant_ctrl_if.slave   bus
);

    if (!ssy_in_range(GRANT_LATENCY, 1, 15)) begin : g_bad_lat
        $fatal(1, "ssy_grant_ctrl: GRANT_LATENCY %0d out of range 1..15", GRANT_LATENCY);
    end
    if (!ssy_in_range(GRANT_LEN, 1, 15)) begin : g_bad_len
        $fatal(1, "ssy_grant_ctrl: GRANT_LEN %0d out of range 1..15", GRANT_LEN);
    end

    // WAIT lasts GRANT_LATENCY-1 cycles (the request cycle itself counts toward
    // the latency), so the counter is loaded with one less than that and WAIT
    // exits on the zero flag. GRANT lasts GRANT_LEN cycles the same way.
    localparam logic [CNT_W-1:0] WAIT_LD =
        CNT_W'((GRANT_LATENCY > 1) ? GRANT_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] LEN_LD  = CNT_W'(GRANT_LEN - 1);
    localparam int               MAX_LD  =
        (GRANT_LATENCY > GRANT_LEN) ? GRANT_LATENCY - 1 : GRANT_LEN - 1;

    state_t           state;
    logic             idle_q;
    logic             granted_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_ld_val;
    logic             cnt_dec;
    logic             cnt_zero;

    ssy_down_counter #(.MAX_VAL(MAX_LD)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Counter control mirrors the FSM transitions below.
    always_comb begin
        cnt_load   = 1'b0;
        cnt_ld_val = '0;
        cnt_dec    = 1'b0;
        unique case (state)
            IDLE: if (bus.request) begin
                cnt_load   = 1'b1;
                cnt_ld_val = (GRANT_LATENCY == 1) ? LEN_LD : WAIT_LD;
            end
            WAIT: if (cnt_zero) begin
                cnt_load   = 1'b1;
                cnt_ld_val = LEN_LD;
            end else begin
                cnt_dec    = 1'b1;
            end
            GRANT: cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idle_q    <= 1'b1;
            granted_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.request) begin
                    idle_q <= 1'b0;
                    if (GRANT_LATENCY == 1) begin
                        state     <= GRANT;
                        granted_q <= 1'b1;
                    end else begin
                        state     <= WAIT;
                    end
                end
                WAIT: if (cnt_zero) begin
                    state     <= GRANT;
                    granted_q <= 1'b1;
                end
                GRANT: if (cnt_zero) begin
                    state     <= IDLE;
                    idle_q    <= 1'b1;
                    granted_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    idle_q    <= 1'b1;
                    granted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.idle    = idle_q;
    assign bus.granted = granted_q;

`ifdef SSY_ASSERT_EN
    a_req_idle: assume property (@(posedge clk) disable iff (reset)
        bus.request |-> bus.idle);

    a_excl: assert property (@(posedge clk) disable iff (reset)
        !(bus.idle && bus.granted));

    a_latency: assert property (@(posedge clk) disable iff (reset)
        bus.request && bus.idle |-> ##GRANT_LATENCY bus.granted);

    a_len: assert property (@(posedge clk) disable iff (reset)
        $rose(bus.granted) |-> bus.granted [*GRANT_LEN] ##1 !bus.granted);

    a_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown({bus.idle, bus.granted}));

    // Next request accepted in the first idle cycle after a grant.
    c_b2b: cover property (@(posedge clk) disable iff (reset)
        $fell(bus.granted) && bus.idle && bus.request);
`endif

endmodule

// File: tb/tb_ssy_grant_ctrl.sv
module tb_ssy_grant_ctrl;
    import ssy_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ssy_grant_ctrl_if bus_a ();
    ssy_grant_ctrl_if bus_b ();

    ssy_grant_ctrl #(.GRANT_LATENCY(2), .GRANT_LEN(1)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    ssy_grant_ctrl #(.GRANT_LATENCY(1), .GRANT_LEN(3)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference timing: t = cycles since the accepted request cycle (-1 = idle).
    function automatic int nxt(input int t, input bit acc, input int tot);
        int n;
        if (acc) return 1;
        if (t < 0) return -1;
        n = t + 1;
        return (n == tot) ? -1 : n;
    endfunction

    int  t_a, t_b;
    bit  r, acc_a, acc_b;

    initial begin
        bus_a.request = 1'b0;
        bus_b.request = 1'b0;
        reset = 1'b1;
        repeat (2) step();
        chk("rst_a_idle",    32'(bus_a.idle),    1);
        chk("rst_a_granted", 32'(bus_a.granted), 0);
        chk("rst_b_idle",    32'(bus_b.idle),    1);
        chk("rst_b_granted", 32'(bus_b.granted), 0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("quiet_idle",    32'(bus_a.idle),    1);
            chk("quiet_granted", 32'(bus_a.granted), 0);
        end

        // Defaults (2,1): single request
        bus_a.request = 1'b1;
        step();
        bus_a.request = 1'b0;
        chk("d_c1_idle", 32'(bus_a.idle), 0);  chk("d_c1_gr", 32'(bus_a.granted), 0);
        step();
        chk("d_c2_idle", 32'(bus_a.idle), 0);  chk("d_c2_gr", 32'(bus_a.granted), 1);
        step();
        chk("d_c3_idle", 32'(bus_a.idle), 1);  chk("d_c3_gr", 32'(bus_a.granted), 0);

        // Request held through busy cycles is ignored
        bus_a.request = 1'b1;
        step();
        chk("ign_c1_idle", 32'(bus_a.idle), 0); chk("ign_c1_gr", 32'(bus_a.granted), 0);
        step();
        chk("ign_c2_idle", 32'(bus_a.idle), 0); chk("ign_c2_gr", 32'(bus_a.granted), 1);
        bus_a.request = 1'b0;
        step();
        chk("ign_c3_idle", 32'(bus_a.idle), 1); chk("ign_c3_gr", 32'(bus_a.granted), 0);
        step();
        chk("ign_c4_idle", 32'(bus_a.idle), 1); chk("ign_c4_gr", 32'(bus_a.granted), 0);

        // Back-to-back: busy, grant, idle repeating
        bus_a.request = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("b2b_idle", 32'(bus_a.idle),    (i % 3 == 2) ? 1 : 0);
            chk("b2b_gr",   32'(bus_a.granted), (i % 3 == 1) ? 1 : 0);
        end
        bus_a.request = 1'b0;
        step();
        chk("b2b_end_idle", 32'(bus_a.idle), 1);
        chk("b2b_end_gr",   32'(bus_a.granted), 0);

        // Parameters (1,3)
        bus_b.request = 1'b1;
        step();
        bus_b.request = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("p13_idle", 32'(bus_b.idle),    0);
            chk("p13_gr",   32'(bus_b.granted), 1);
            step();
        end
        chk("p13_end_idle", 32'(bus_b.idle),    1);
        chk("p13_end_gr",   32'(bus_b.granted), 0);

        // Asynchronous reset in the middle of GRANT
        bus_a.request = 1'b1;
        step();
        bus_a.request = 1'b0;
        step();
        chk("arst_pre_gr", 32'(bus_a.granted), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_idle", 32'(bus_a.idle),    1);
        chk("arst_gr",   32'(bus_a.granted), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_idle", 32'(bus_a.idle),    1);
            chk("post_rst_gr",   32'(bus_a.granted), 0);
        end

        // Random requests on both instances against the timing model
        t_a = -1;
        t_b = -1;
        for (int i = 0; i < 300; i++) begin
            r = 1'($urandom_range(0, 1));
            bus_a.request = r;
            bus_b.request = r;
            acc_a = r && (t_a < 0);
            acc_b = r && (t_b < 0);
            step();
            t_a = nxt(t_a, acc_a, 3);
            t_b = nxt(t_b, acc_b, 4);
            chk("rnd_a_idle", 32'(bus_a.idle),    (t_a < 0) ? 1 : 0);
            chk("rnd_a_gr",   32'(bus_a.granted), (t_a == 2) ? 1 : 0);
            chk("rnd_b_idle", 32'(bus_b.idle),    (t_b < 0) ? 1 : 0);
            chk("rnd_b_gr",   32'(bus_b.granted), (t_b >= 1) ? 1 : 0);
        end
        bus_a.request = 1'b0;
        bus_b.request = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
